// File: rtl/serial_mag_compare_ctrl_pkg.sv
// serial_mag_compare_ctrl_pkg: FSM state encoding and one-hot result constants shared by the comparator files
package serial_mag_compare_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam logic [2:0] GT   = 3'b100;
    localparam logic [2:0] LT   = 3'b010;
    localparam logic [2:0] EQ   = 3'b001;
    localparam logic [2:0] NONE = 3'b000;
endpackage

// File: rtl/serial_mag_compare_ctrl_bit_compare_cell.sv
// bit_compare_cell: combinational 1-bit three-way compare; ports a_i, b_i in, y_o one-hot GT/LT/EQ out
module bit_compare_cell
    import serial_mag_compare_ctrl_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    output logic [2:0] y_o
);
    assign y_o = (a_i & ~b_i) ? GT : (~a_i & b_i) ? LT : EQ;
endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// serial_mag_compare_ctrl: MSB-first serial magnitude compare with early exit; start/a/b in, busy/done/y/bits_scanned out
module serial_mag_compare_ctrl
    import serial_mag_compare_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    output logic                         busy,
    output logic                         done,
    output logic [2:0]                   y,
    output logic [$clog2(WIDTH+1)-1:0]   bits_scanned
);
    localparam int CW = $clog2(WIDTH+1);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d, bits_q, bits_d;
    logic [2:0]       y_q, y_d, cell_y;
    logic             last;
    bit_compare_cell u_cell (
        .a_i (a_q[WIDTH-1]),
        .b_i (b_q[WIDTH-1]),
        .y_o (cell_y)
    );
    assign last = cnt_q == CW'(WIDTH - 1);
    // A mismatch and an equal final bit both finish here; the cell reports EQ in the latter case
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        bits_d  = bits_q;
        case (state_q)
            IDLE: if (start) begin
                a_d     = a;
                b_d     = b;
                cnt_d   = '0;
                state_d = SCAN;
            end
            SCAN: if (cell_y != EQ || last) begin
                y_d     = cell_y;
                bits_d  = cnt_q + CW'(1);
                state_d = DONE;
            end else begin
                a_d   = {a_q[WIDTH-2:0], 1'b0};
                b_d   = {b_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            y_q     <= NONE;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            bits_q  <= bits_d;
        end
    end
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign y            = y_q;
    assign bits_scanned = bits_q;
endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// tb_serial_mag_compare_ctrl: directed stimulus with a scoreboard queue checked by a done-driven monitor
module tb_serial_mag_compare_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done;
    logic [2:0] y;
    logic [3:0] bits_scanned;
    typedef struct {
        logic [2:0] y;
        int         bits;
        int         cyc;
    } exp_t;
    exp_t sb[$];
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    serial_mag_compare_ctrl #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .y            (y),
        .bits_scanned (bits_scanned)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) chk("spurious_done", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_y", {29'd0, y}, {29'd0, e.y});
                chk("bits_scanned", {28'd0, bits_scanned}, e.bits);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end
    task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] ey,
                         input int ek, input bit track, output int acc);
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
        a = av;
        b = bv;
        start = 1'b1;
        acc = cyc + 1;
        if (track) sb.push_back('{ey, ek, acc + ek});
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask
    initial begin
        int acc;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_y", y, 0);
        chk("rst_bits", bits_scanned, 0);
        @(negedge clk);
        rst = 1'b0;
        issue(8'hA5, 8'hA5, 3'b001, 8, 1, acc);
        drain();
        @(negedge clk);
        chk("hold_busy", busy, 0);
        chk("hold_y", y, 3'b001);
        chk("hold_bits", bits_scanned, 8);
        issue(8'h80, 8'h7F, 3'b100, 1, 1, acc);
        drain();
        issue(8'h01, 8'h02, 3'b010, 7, 1, acc);
        drain();
        issue(8'h01, 8'h02, 3'b010, 7, 1, acc);
        chk("scan_busy", busy, 1);
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < acc + 7) @(negedge clk);
        chk("done_cycle_busy", busy, 1);
        a = 8'h0F;
        b = 8'hF0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_start_ignored", busy, 0);
        drain();
        repeat (12) @(negedge clk);
        issue(8'h00, 8'h00, 3'b001, 8, 0, acc);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_y", y, 0);
        chk("abort_bits", bits_scanned, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        issue(8'h03, 8'h01, 3'b100, 7, 1, acc);
        drain();
        @(negedge clk);
        a = 8'h10;
        b = 8'h10;
        start = 1'b1;
        acc = cyc + 1;
        for (int i = 0; i < 3; i++) sb.push_back('{3'b001, 8, acc + 8 + 10 * i});
        while (cyc < acc + 29) @(negedge clk);
        start = 1'b0;
        drain();
        repeat (15) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
